seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display that shares one BCD-to-7-segment decoder across all digits. Each digit slot in turn: drive that digit's BCD code and blank flag to the shared decoder, then enable that digit's anode. Host updates are double-buffered and committed only at a frame boundary, so a display update never tears. Sits between the host/counter logic and the shared decoder plus anode drivers.

Parameters:
NDIG, 4, number of digits scanned (2..8)
DIV, 50000, clock cycles per digit slot (>=4)
BLANK, 16, guard cycles at start of each slot with all anodes off (1..DIV-2); anti-ghosting

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load  in  1  update request; accepted when load && ready
value  in  4*NDIG  BCD digits; digit i = value[4i+3:4i]; digit 0 = least significant
dp_in  in  NDIG  decimal-point per digit
lzb_en  in  1  leading-zero blanking enable (level, sampled every cycle)
ready  out  1  shadow buffer free; load accepted
bcd_out  out  4  BCD code to the shared decoder
blank_out  out  1  1 = decoder output must be blanked
dp_out  out  1  decimal point of the current digit
dig_en  out  NDIG  one-hot anode enable, active-high; all zero in guard
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- All outputs are registered.
- Reset values:
  - ready=1, bcd_out=0, blank_out=1, dp_out=0, dig_en=0, frame_tick=0.
  - Internal: digit index=0, slot counter=0, state=GUARD.
  - Active and shadow buffers are 0; pending=0.
- Reset mid-scan aborts the scan immediately and discards any pending update.
- Slot counter cnt runs 0..DIV-1, then wraps to 0 and advances the digit index.
- Digit index runs 0..NDIG-1, then wraps to 0.
- States:
  - GUARD: cnt < BLANK. dig_en=0. bcd_out, blank_out and dp_out already show the current digit.
  - ON: BLANK <= cnt <= DIV-1. dig_en[idx]=1.
  - ON->GUARD happens at cnt=DIV-1.
- Output timing: dig_en rises in the cycle after cnt reaches BLANK and falls in the cycle after cnt=DIV-1.
- Slot timing: each digit gets exactly DIV-BLANK lit cycles per slot. One frame = NDIG*DIV cycles.
- Frame boundary: the cycle in which cnt=DIV-1 and idx=NDIG-1.
  - frame_tick=1 in the following cycle.
  - If pending=1: active buffer <= shadow, pending <= 0, ready <= 1 (visible in the next cycle).
  - The first digit 0 of the new frame shows the new data.
- Load handshake:
  - load && ready captures value and dp_in into shadow; pending <= 1, ready <= 0 in the next cycle.
  - load while ready=0 is ignored: no overwrite, no error.
  - Load and commit cannot coincide, because ready=0 whenever pending=1.
- Digit code: bcd_out = active digit[idx].
- Invalid code: if the code > 9, bcd_out=4'hF and blank_out=1. dp_out still follows dp.
- Leading-zero blanking (lzb_en=1):
  - Digit i (i>0) is blanked if it and all higher digits are 0.
  - Digit 0 is never blanked by this rule.
  - A digit with dp set stops blanking at that digit and below.
  - A blanked digit gives blank_out=1 and dp_out=0.
- lzb_en change: takes effect at the next slot's GUARD output update. It never changes outputs during ON.

Decomposition:
- Shared package seg_pkg:
  - BCD_BLANK = 4'hF
  - BCD_MAX = 4'd9
  - width helper function clog2 for the index and counter
  - digit-slot state encoding (GUARD, ON)
- Natural sub-module: scan_timer. It holds cnt and idx and produces the slot_start, guard_end, slot_end and frame_end strobes.
- seg_scan_ctrl adds buffering, the handshake and digit formatting.
- The shared decoder is instantiated beside this block at display top level, not inside it.

Test Plan:
All scenarios use NDIG=4, DIV=8, BLANK=2.
- Reset: hold rst_n=0 for 3 cycles mid-frame -> next cycle dig_en=0, blank_out=1, ready=1, idx=0; first dig_en=4'b0001 appears 3 cycles after release.
- Scan timing: load value=16'h1234 -> after commit, dig_en sequence 0001,0010,0100,1000; each lit 6 cycles after 2 off; bcd_out = 4,3,2,1; frame_tick period 32 cycles.
- Double buffer: load 16'h1234, then load 16'h5678 mid-frame before commit -> second load ignored (ready=0); after frame_tick ready=1 and display still 1234; a new load of 5678 shows at the next frame's digit 0 only.
- Leading-zero blanking: value=16'h0070, lzb_en=1 -> digits 3 and 2 blank_out=1, digit 1 bcd_out=7, digit 0 bcd_out=0 and blank_out=0. Same with dp_in=4'b0100 -> digit 2 shows 0 and is not blanked.
- Invalid code: value=16'h00A5 -> digit 1 bcd_out=4'hF, blank_out=1; other digits normal.
- lzb_en toggled during an ON phase -> blank_out is unchanged until the next slot's GUARD.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, slot-state encoding and width helper for the 7-segment scan controller.
package seg_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } slot_state_t;

    // Ceiling log2 with a floor of 1 so single-value ranges still get a real bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n)
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Digit-slot timebase: slot counter and digit index plus the strobes that
// mark slot start, end of the anti-ghosting guard, slot end and frame end.
module scan_timer
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16,
    parameter int IW    = clog2(NDIG)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          slot_start,
    output logic          guard_end,
    output logic          slot_end,
    output logic          frame_end
);

    localparam int CW = clog2(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign slot_start = (cnt == '0);
    assign guard_end  = (cnt == CW'(BLANK - 1));
    assign slot_end   = (cnt == CW'(DIV - 1));
    assign frame_end  = slot_end && (idx == IW'(NDIG - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display: double-buffered
// host updates committed at frame boundaries, digit formatting for a shared decoder.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              lzb_en,
    output logic              ready,
    output logic [3:0]        bcd_out,
    output logic              blank_out,
    output logic              dp_out,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_tick
);

    localparam int IW = clog2(NDIG);

    logic [IW-1:0]     idx;
    logic              slot_start;
    logic              guard_end;
    logic              slot_end;
    logic              frame_end;

    logic [4*NDIG-1:0] active_val;
    logic [4*NDIG-1:0] shadow_val;
    logic [NDIG-1:0]   active_dp;
    logic [NDIG-1:0]   shadow_dp;
    logic              pending;

    slot_state_t       state;
    slot_state_t       state_next;

    logic [NDIG-1:0]   lz_mask;
    logic              lz_run;
    logic [3:0]        cur_code;
    logic              cur_dp;
    logic [NDIG-1:0]   dig_en_next;
    logic [3:0]        bcd_next;
    logic              blank_next;
    logic              dp_next;

    scan_timer #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .BLANK (BLANK),
        .IW    (IW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .slot_start (slot_start),
        .guard_end  (guard_end),
        .slot_end   (slot_end),
        .frame_end  (frame_end)
    );

    // Commit and capture are mutually exclusive: ready is low whenever pending is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_val <= '0;
            active_dp  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            ready      <= 1'b1;
        end else if (frame_end && pending) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
            pending    <= 1'b0;
            ready      <= 1'b1;
        end else if (load && ready) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
            ready      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= GUARD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            GUARD:   if (guard_end) state_next = ON;
            ON:      if (slot_end)  state_next = GUARD;
            default: state_next = GUARD;
        endcase
    end

    // A digit is a leading zero while it and everything above it are zero without a dp.
    always_comb begin
        lz_run  = lzb_en;
        lz_mask = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            lz_run     = lz_run && (active_val[4*i +: 4] == 4'd0) && !active_dp[i];
            lz_mask[i] = lz_run;
        end
    end

    assign cur_code = active_val[4*idx +: 4];
    assign cur_dp   = active_dp[idx];

    // Formatting is refreshed only at slot start so lzb_en never disturbs a lit digit.
    always_comb begin
        dig_en_next = '0;
        if (state == ON)
            dig_en_next[idx] = 1'b1;
        bcd_next   = bcd_out;
        blank_next = blank_out;
        dp_next    = dp_out;
        if (slot_start) begin
            if (lz_mask[idx]) begin
                bcd_next   = cur_code;
                blank_next = 1'b1;
                dp_next    = 1'b0;
            end else if (cur_code > BCD_MAX) begin
                bcd_next   = BCD_BLANK;
                blank_next = 1'b1;
                dp_next    = cur_dp;
            end else begin
                bcd_next   = cur_code;
                blank_next = 1'b0;
                dp_next    = cur_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_en     <= '0;
            bcd_out    <= 4'd0;
            blank_out  <= 1'b1;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            dig_en     <= dig_en_next;
            bcd_out    <= bcd_next;
            blank_out  <= blank_next;
            dp_out     <= dp_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, DIV=8, BLANK=2): directed scenarios
// followed by randomized traffic, all compared against a cycle-count based display model.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lzb_en;
    logic        ready;
    logic [3:0]  bcd_out;
    logic        blank_out;
    logic        dp_out;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: k counts clock edges since reset release; everything else follows from it.
    int          k;
    logic [15:0] m_act_val;
    logic [15:0] m_shadow_val;
    logic [3:0]  m_act_dp;
    logic [3:0]  m_shadow_dp;
    bit          m_pend;
    bit          m_ready;
    logic [3:0]  e_bcd;
    bit          e_blank;
    bit          e_dp;
    bit          e_lz;
    logic [3:0]  e_dig_en;
    bit          e_tick;
    bit          cur_lzb;

    seg_scan_ctrl #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .ready      (ready),
        .bcd_out    (bcd_out),
        .blank_out  (blank_out),
        .dp_out     (dp_out),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s (k=%0d): got %0h, want %0h", tag, k, observed, expected);
        end
    endtask

    task automatic resetModel();
        k            = 0;
        m_act_val    = '0;
        m_act_dp     = '0;
        m_shadow_val = '0;
        m_shadow_dp  = '0;
        m_pend       = 1'b0;
        m_ready      = 1'b1;
        e_bcd        = 4'd0;
        e_blank      = 1'b1;
        e_dp         = 1'b0;
        e_lz         = 1'b0;
        e_dig_en     = '0;
        e_tick       = 1'b0;
    endtask

    task automatic modelDisplay(input int d, input bit lzb);
        logic [3:0] code;
        bit lead;
        code = m_act_val[4*d +: 4];
        lead = lzb && (d > 0);
        for (int j = d; j < NDIG; j++)
            if (m_act_val[4*j +: 4] != 4'd0 || m_act_dp[j])
                lead = 1'b0;
        e_lz = lead;
        if (lead) begin
            e_bcd   = code;
            e_blank = 1'b1;
            e_dp    = 1'b0;
        end else if (code > 4'd9) begin
            e_bcd   = 4'hF;
            e_blank = 1'b1;
            e_dp    = m_act_dp[d];
        end else begin
            e_bcd   = code;
            e_blank = 1'b0;
            e_dp    = m_act_dp[d];
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ld, input logic [15:0] val,
                                 input logic [3:0] dp, input bit lzb);
        int slot;
        int digit;
        @(negedge clk);
        rst_n  = ~rst;
        load   = ld;
        value  = val;
        dp_in  = dp;
        lzb_en = lzb;
        @(posedge clk);
        if (rst) begin
            resetModel();
        end else begin
            slot  = k % DIV;
            digit = (k / DIV) % NDIG;
            if (slot == 0)
                modelDisplay(digit, lzb);
            e_dig_en = (slot >= BLANK) ? 4'(1 << digit) : 4'd0;
            e_tick   = (k % FRAME == FRAME - 1);
            if (e_tick && m_pend) begin
                m_act_val = m_shadow_val;
                m_act_dp  = m_shadow_dp;
                m_pend    = 1'b0;
                m_ready   = 1'b1;
            end else if (ld && m_ready) begin
                m_shadow_val = val;
                m_shadow_dp  = dp;
                m_pend       = 1'b1;
                m_ready      = 1'b0;
            end
            k++;
        end
        #1;
        checkOutput("dig_en", 32'(dig_en), 32'(e_dig_en));
        checkOutput("frame_tick", 32'(frame_tick), 32'(e_tick));
        checkOutput("ready", 32'(ready), 32'(m_ready));
        checkOutput("blank_out", 32'(blank_out), 32'(e_blank));
        checkOutput("dp_out", 32'(dp_out), 32'(e_dp));
        if (!e_lz)
            checkOutput("bcd_out", 32'(bcd_out), 32'(e_bcd));
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, cur_lzb);
    endtask

    task automatic loadValue(input logic [15:0] val, input logic [3:0] dp);
        applyStimulus(1'b0, 1'b1, val, dp, cur_lzb);
    endtask

    function automatic logic [15:0] randDigits();
        logic [15:0] v;
        for (int i = 0; i < NDIG; i++)
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
        return v;
    endfunction

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        value   = '0;
        dp_in   = '0;
        lzb_en  = 1'b0;
        cur_lzb = 1'b0;
        resetModel();

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        runIdle(13);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        runIdle(10);

        loadValue(16'h1234, 4'h0);
        runIdle(5);
        loadValue(16'h5678, 4'h0);
        runIdle(70);
        loadValue(16'h5678, 4'h0);
        runIdle(70);

        cur_lzb = 1'b1;
        loadValue(16'h0070, 4'h0);
        runIdle(70);
        loadValue(16'h0070, 4'b0100);
        runIdle(70);
        loadValue(16'h0070, 4'h0);
        runIdle(40);
        for (int i = 0; i < 64; i++) begin
            if (i % 3 == 0)
                cur_lzb = ~cur_lzb;
            runIdle(1);
        end

        cur_lzb = 1'b0;
        loadValue(16'h00A5, 4'b0010);
        runIdle(70);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0)
                cur_lzb = ~cur_lzb;
            if ($urandom_range(0, 299) == 0)
                applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, cur_lzb);
            else if ($urandom_range(0, 9) == 0)
                applyStimulus(1'b0, 1'b1, randDigits(),
                              4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                              cur_lzb);
            else
                runIdle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
